// File: rtl/factor_disp_pkg.sv
// Shared types and constants for the factor display sequencer.
// Included by every file of the block; FACTOR_DISP_GAP_EN selects the blank gap between factors.
package factor_disp_pkg;

    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] BLANK   = 4'hF;
    localparam logic [IDX_W-1:0] DASH    = 4'h0;
    localparam logic [IDX_W-1:0] MAX_IDX = 4'd9;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SHOW    = 2'd2,
        GAP     = 2'd3
    } state_t;

    // Only indices 1..MAX_IDX name a real prime; anything else is dropped on entry.
    function automatic logic is_factor(input logic [IDX_W-1:0] idx);
        return (idx != '0) && (idx <= MAX_IDX);
    endfunction

endpackage

// File: rtl/factor_disp_seq_timer.sv
// Down counter that reports terminal count; provides the SHOW and GAP hold durations.
// A load overrides counting; the count parks at zero until the next load.
module disp_hold_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/factor_disp_seq.sv
// Collects prime-factor indices from the factorization engine and cycles them on a digit display.
// Define FACTOR_DISP_GAP_EN to insert a blank gap of HOLD_CYC/4 cycles between displayed factors.
module factor_disp_seq
    import factor_disp_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int HOLD_CYC = 50_000_000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             FVALID,
    input  logic [IDX_W-1:0] FIDX,
    output logic             FREADY,
    input  logic             FDONE,
    output logic [IDX_W-1:0] DOUT,
    output logic             SHOWING,
    output logic             OVF,
    output logic [1:0]       DBG_STATE
);

    // Handshake: a factor transfers on a rising edge where FVALID and FREADY are both high;
    // FVALID while the list is full still completes from the engine's view, sets OVF and is lost.

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(HOLD_CYC);
    localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYC - 1);
`ifdef FACTOR_DISP_GAP_EN
    localparam int GAP_CYC = (HOLD_CYC / 4 > 0) ? HOLD_CYC / 4 : 1;
    localparam logic [TW-1:0] GAP_LD = TW'(GAP_CYC - 1);
`endif

    state_t           state, state_n;
    logic [CW-1:0]    count, count_n;
    logic [AW-1:0]    rd_ptr, rd_n, rd_wrap;
    logic [IDX_W-1:0] list [DEPTH];
    logic             ovf_n, fready_n, showing_n;
    logic [IDX_W-1:0] dout_n;
    logic             full, accept, wr_en;
    logic [AW-1:0]    wr_idx;
    logic             tmr_load, tmr_en, tmr_tc;
    logic [TW-1:0]    tmr_val;

    disp_hold_timer #(.W(TW)) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .tc       (tmr_tc)
    );

    assign full    = (count == CW'(DEPTH));
    assign accept  = (state == COLLECT) && FVALID && !full;
    assign wr_idx  = count[AW-1:0];
    assign rd_wrap = ({1'b0, rd_ptr} == (count - CW'(1))) ? '0 : rd_ptr + AW'(1);

    always_comb begin
        state_n  = state;
        count_n  = count;
        rd_n     = rd_ptr;
        ovf_n    = OVF;
        wr_en    = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = HOLD_LD;

        if (START) begin
            state_n  = COLLECT;
            count_n  = '0;
            rd_n     = '0;
            ovf_n    = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = '0;
        end else begin
            case (state)
                IDLE: begin
                end
                COLLECT: begin
                    if (accept && is_factor(FIDX)) begin
                        wr_en   = 1'b1;
                        count_n = count + CW'(1);
                    end
                    if (FVALID && full) begin
                        ovf_n = 1'b1;
                    end
                    if (FDONE) begin
                        state_n  = SHOW;
                        rd_n     = '0;
                        tmr_load = 1'b1;
                    end
                end
                SHOW: begin
                    // An empty list shows the dash forever, so the timer is left idle.
                    if (count != '0) begin
                        tmr_en = 1'b1;
                        if (tmr_tc) begin
                            tmr_load = 1'b1;
`ifdef FACTOR_DISP_GAP_EN
                            state_n = GAP;
                            tmr_val = GAP_LD;
`else
                            rd_n = rd_wrap;
`endif
                        end
                    end
                end
`ifdef FACTOR_DISP_GAP_EN
                GAP: begin
                    tmr_en = 1'b1;
                    if (tmr_tc) begin
                        state_n  = SHOW;
                        rd_n     = rd_wrap;
                        tmr_load = 1'b1;
                    end
                end
`endif
                default: state_n = IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they register on the same edge as it.
        dout_n = BLANK;
        if (state_n == SHOW) begin
            if (count_n == '0) begin
                dout_n = DASH;
            end else if (wr_en && (wr_idx == rd_n)) begin
                dout_n = FIDX;
            end else begin
                dout_n = list[rd_n];
            end
        end
        fready_n  = (state_n == COLLECT) && (count_n < CW'(DEPTH));
        showing_n = (state_n == SHOW) || (state_n == GAP);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            count   <= '0;
            rd_ptr  <= '0;
            OVF     <= 1'b0;
            DOUT    <= BLANK;
            FREADY  <= 1'b0;
            SHOWING <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                list[i] <= '0;
            end
        end else begin
            state   <= state_n;
            count   <= count_n;
            rd_ptr  <= rd_n;
            OVF     <= ovf_n;
            DOUT    <= dout_n;
            FREADY  <= fready_n;
            SHOWING <= showing_n;
            if (wr_en) begin
                list[wr_idx] <= FIDX;
            end
        end
    end

    assign DBG_STATE = state;

endmodule

// File: doc/factor_disp_seq.md
FACTOR_DISP_SEQ -- requirements
Module: factor_disp_seq

Interface
REQ-001 Parameter DEPTH, 8, factor list capacity in entries (power of two, 2..16).
REQ-002 Parameter HOLD_CYC, 50_000_000, number of CLK cycles each factor stays on the display (>=2).
REQ-003 CLK  input  1  single system clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 START  input  1  one-cycle pulse: discard the current list and begin collecting for a new number.
REQ-006 FVALID  input  1  factor offer from the factorization engine.
REQ-007 FIDX  input  4  prime index of the offered factor; 0 means "no prime", 1..9 select primes 2..23.
REQ-008 FREADY  output  1  block accepts a factor this cycle.
REQ-009 FDONE  input  1  one-cycle pulse: the engine has offered its last factor.
REQ-010 DOUT  output  4  index to the digit decoder; 4'hF means blank.
REQ-011 SHOWING  output  1  high while the display is in SHOW or GAP.
REQ-012 OVF  output  1  sticky; the list overflowed since the last START.

Function
REQ-013 The FSM SHALL have the states IDLE, COLLECT, SHOW and GAP.
REQ-014 In IDLE: DOUT=4'hF, FREADY=0; START -> COLLECT, with the list cleared and OVF cleared on the same edge.
REQ-015 In COLLECT: FREADY=1 while count<DEPTH; a factor is written when FVALID&FREADY, appended at the write pointer.
REQ-016 An FIDX of 0 or >9 is accepted (handshake completes) and discarded; it is never stored.
REQ-017 FVALID while count==DEPTH: FREADY=0, OVF is set on that cycle, and the factor is dropped (the engine must not stall forever).
REQ-018 FDONE in COLLECT with count>0 -> SHOW at entry 0; with count==0 -> SHOW with DOUT=4'h0 (dash) continuously until START.
REQ-019 FVALID&FREADY on the same cycle as FDONE: that factor is stored before the transition.
REQ-020 In SHOW: DOUT=list[rd_ptr] for exactly HOLD_CYC cycles, then -> GAP (macro on) or next entry (macro off).
REQ-021 rd_ptr wraps from count-1 to 0; the display cycles through the list indefinitely until START.
REQ-022 START in any state other than IDLE restarts COLLECT on the next edge, aborts the hold timer and sets DOUT=4'hF.
REQ-023 START and FDONE on the same cycle: START wins.
REQ-024 A duplicate factor (e.g. 2,2,3 for 12) SHALL be stored and displayed as separate entries.
REQ-025 All outputs SHALL be registered; DOUT changes exactly one cycle after the internal state change.

Reset
REQ-026 While RST=1: state=IDLE, count=0, pointers=0, timer=0, DOUT=4'hF, FREADY=0, SHOWING=0, OVF=0.
REQ-027 RST asserted mid-SHOW or mid-COLLECT SHALL discard the list; there is no resume after reset.

Configuration
REQ-028 Macro FACTOR_DISP_GAP_EN defined: the GAP state exists, DOUT=4'hF for HOLD_CYC/4 cycles between consecutive factors (including at the wrap), so that repeated factors are distinguishable.
REQ-029 FACTOR_DISP_GAP_EN undefined: the GAP state is absent, SHOW advances directly to the next entry, and the GAP encoding is unused.

Structure
REQ-030 Shared package factor_disp_pkg: state enum, IDX_W=4, BLANK=4'hF, DASH=4'h0, MAX_IDX=9.
REQ-031 A single sub-module disp_hold_timer (load/terminal-count down counter, width $clog2(HOLD_CYC)) SHALL provide the SHOW and GAP durations.
REQ-032 The list SHALL be a register array; no RAM inference is required.

Verification (HOLD_CYC=8)
REQ-033 START, factors 1,1,2, FDONE -> DOUT sequence 1 (8 cyc), 1 (8), 2 (8), 1 ... ; with GAP_EN there is 4'hF for 2 cycles between each.
REQ-034 START, 9 valid factors with DEPTH=8 -> the 9th is dropped, OVF=1, FREADY=0 on that cycle, and 8 entries are displayed.
REQ-035 START, FIDX=0 and FIDX=12 offered, then 3, FDONE -> only 3 is displayed, repeating.
REQ-036 START then FDONE with no factors -> DOUT=4'h0 is held steady for more than 3*HOLD_CYC cycles.
REQ-037 START pulse 3 cycles into the second SHOW entry -> next cycle DOUT=4'hF, FREADY=1, OVF=0.
REQ-038 RST asserted asynchronously mid-SHOW (between edges) -> DOUT=4'hF immediately, state IDLE after release.
